// File: rtl/spi_master_multi_cs_if.sv
// Host-side control/status bundle plus the SPI pins of spi_master_multi_cs.
// The master modport is the SPI master itself; slave is whoever drives the config and pins.
interface spi_master_multi_cs_if #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned CLK_DIV_W = 8
);
  localparam int unsigned SEL_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned BITS_W = $clog2(DATA_W + 1);

  logic                 i_en;
  logic                 i_cpol;
  logic                 i_cpha;
  logic                 i_lsb_first;
  logic [SEL_W-1:0]     i_cs_sel;
  logic [CLK_DIV_W-1:0] i_clk_div;
  logic [DATA_W-1:0]    i_data_master;
  logic                 i_clr_flg;
  logic                 i_MISO;
  logic                 o_MOSI;
  logic                 o_SCK;
  logic [NUM_CS-1:0]    o_CS;
  logic [DATA_W-1:0]    o_data_rx;
  logic                 o_busy;
  logic                 o_done_flg;
  logic [BITS_W-1:0]    o_bits;

  modport master (
    input  i_en, i_cpol, i_cpha, i_lsb_first, i_cs_sel, i_clk_div, i_data_master,
           i_clr_flg, i_MISO,
    output o_MOSI, o_SCK, o_CS, o_data_rx, o_busy, o_done_flg, o_bits
  );

  modport slave (
    output i_en, i_cpol, i_cpha, i_lsb_first, i_cs_sel, i_clk_div, i_data_master,
           i_clr_flg, i_MISO,
    input  o_MOSI, o_SCK, o_CS, o_data_rx, o_busy, o_done_flg, o_bits
  );
endinterface

// File: rtl/spi_master_multi_cs.sv
// SPI master: four CPOL/CPHA modes, MSB/LSB first, N active-low chip selects,
// programmable SCK divider and CS setup/hold guard times; sticky done flag.
module spi_master_multi_cs #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned NUM_CS    = 4,
  parameter int unsigned CLK_DIV_W = 8,
  parameter int unsigned CS_SETUP  = 2,
  parameter int unsigned CS_HOLD   = 2
) (
  input logic                   i_clk,
  input logic                   i_rst,
  spi_master_multi_cs_if.master bus
);
  localparam int unsigned SEL_W     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int unsigned SEL_CMP_W = SEL_W + 1;
  localparam int unsigned BITS_W    = $clog2(DATA_W + 1);
  localparam int unsigned EDGE_W    = $clog2(2 * DATA_W);
  localparam int unsigned GUARD_MAX = (CS_SETUP > CS_HOLD) ? CS_SETUP : CS_HOLD;
  localparam int unsigned GUARD_W   = $clog2(GUARD_MAX + 1);

  typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

  state_e               state_q, state_d;
  logic                 cpol_q, cpol_d, cpha_q, cpha_d, lsb_q, lsb_d;
  logic [CLK_DIV_W-1:0] div_q, div_d, div_cnt_q, div_cnt_d;
  logic [EDGE_W-1:0]    edge_q, edge_d;
  logic [GUARD_W-1:0]   guard_q, guard_d;
  logic [DATA_W-1:0]    tx_q, tx_d, rx_q, rx_d, data_rx_q, data_rx_d;
  logic                 sck_q, sck_d, mosi_q, mosi_d, busy_q, busy_d, done_q, done_d;
  logic [NUM_CS-1:0]    cs_q, cs_d;
  logic [BITS_W-1:0]    bits_q, bits_d;
  logic                 start_c, sample_c, last_edge_c;

  assign start_c     = bus.i_en && ({1'b0, bus.i_cs_sel} < SEL_CMP_W'(NUM_CS));
  // Even edge index is the leading edge; cpha selects which edge samples.
  assign sample_c    = (edge_q[0] == 1'b0) ^ cpha_q;
  assign last_edge_c = (edge_q == EDGE_W'(2 * DATA_W - 1));

  always_comb begin
    state_d   = state_q;
    cpol_d    = cpol_q;
    cpha_d    = cpha_q;
    lsb_d     = lsb_q;
    div_d     = div_q;
    div_cnt_d = div_cnt_q;
    edge_d    = edge_q;
    guard_d   = guard_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    data_rx_d = data_rx_q;
    sck_d     = sck_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = done_q;
    cs_d      = cs_q;
    bits_d    = bits_q;

    if (bus.i_clr_flg) done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        cs_d  = '1;
        sck_d = cpol_q;
        if (start_c) begin
          cpol_d    = bus.i_cpol;
          cpha_d    = bus.i_cpha;
          lsb_d     = bus.i_lsb_first;
          div_d     = bus.i_clk_div;
          tx_d      = bus.i_data_master;
          rx_d      = '0;
          bits_d    = '0;
          div_cnt_d = '0;
          edge_d    = '0;
          guard_d   = '0;
          busy_d    = 1'b1;
          sck_d     = bus.i_cpol;
          cs_d      = ~(NUM_CS'(1) << bus.i_cs_sel);
          state_d   = SETUP;
          // cpha=0 needs the first bit on the line before the leading edge.
          if (!bus.i_cpha) begin
            mosi_d = bus.i_lsb_first ? bus.i_data_master[0] : bus.i_data_master[DATA_W-1];
            tx_d   = bus.i_lsb_first ? (bus.i_data_master >> 1) : (bus.i_data_master << 1);
          end
        end
      end
      SETUP: begin
        guard_d = guard_q + 1'b1;
        if (guard_q == GUARD_W'(CS_SETUP - 1)) begin
          guard_d = '0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (div_cnt_q == div_q) begin
          div_cnt_d = '0;
          sck_d     = ~sck_q;
          edge_d    = edge_q + 1'b1;
          if (sample_c) begin
            rx_d   = lsb_q ? {bus.i_MISO, rx_q[DATA_W-1:1]} : {rx_q[DATA_W-2:0], bus.i_MISO};
            bits_d = bits_q + 1'b1;
          end else if (!last_edge_c) begin
            mosi_d = lsb_q ? tx_q[0] : tx_q[DATA_W-1];
            tx_d   = lsb_q ? (tx_q >> 1) : (tx_q << 1);
          end
          if (last_edge_c) begin
            guard_d = '0;
            state_d = HOLD;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end
      HOLD: begin
        sck_d   = cpol_q;
        guard_d = guard_q + 1'b1;
        if (guard_q == GUARD_W'(CS_HOLD - 1)) begin
          cs_d      = '1;
          data_rx_d = rx_q;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      cpol_q    <= 1'b0;
      cpha_q    <= 1'b0;
      lsb_q     <= 1'b0;
      div_q     <= '0;
      div_cnt_q <= '0;
      edge_q    <= '0;
      guard_q   <= '0;
      tx_q      <= '0;
      rx_q      <= '0;
      data_rx_q <= '0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      cs_q      <= '1;
      bits_q    <= '0;
    end else begin
      state_q   <= state_d;
      cpol_q    <= cpol_d;
      cpha_q    <= cpha_d;
      lsb_q     <= lsb_d;
      div_q     <= div_d;
      div_cnt_q <= div_cnt_d;
      edge_q    <= edge_d;
      guard_q   <= guard_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_rx_q <= data_rx_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      cs_q      <= cs_d;
      bits_q    <= bits_d;
    end
  end

  assign bus.o_MOSI     = mosi_q;
  assign bus.o_SCK      = sck_q;
  assign bus.o_CS       = cs_q;
  assign bus.o_data_rx  = data_rx_q;
  assign bus.o_busy     = busy_q;
  assign bus.o_done_flg = done_q;
  assign bus.o_bits     = bits_q;
endmodule

// File: tb/tb_spi_master_multi_cs.sv
// Directed bench: an 8-bit/4-CS master and a 16-bit/3-CS master, each with a
// behavioural SPI slave that records MOSI in arrival order and returns a fixed word.
module tb_spi_master_multi_cs;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  bit          tgt = 1'b0;
  logic        en = 1'b0, clr = 1'b0, cpol = 1'b0, cpha = 1'b0, lsb = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic [7:0]  div = 8'd0;
  logic [15:0] txw = 16'h0, rxw = 16'h0;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  spi_master_multi_cs_if #(.DATA_W(8),  .NUM_CS(4), .CLK_DIV_W(8)) a_if ();
  spi_master_multi_cs_if #(.DATA_W(16), .NUM_CS(3), .CLK_DIV_W(8)) b_if ();

  spi_master_multi_cs #(.DATA_W(8), .NUM_CS(4), .CLK_DIV_W(8), .CS_SETUP(2), .CS_HOLD(2))
    dut_a (.i_clk(clk), .i_rst(rst_n), .bus(a_if));
  spi_master_multi_cs #(.DATA_W(16), .NUM_CS(3), .CLK_DIV_W(8), .CS_SETUP(2), .CS_HOLD(2))
    dut_b (.i_clk(clk), .i_rst(rst_n), .bus(b_if));

  assign a_if.i_en = en & ~tgt;
  assign b_if.i_en = en & tgt;
  assign a_if.i_clr_flg = clr & ~tgt;
  assign b_if.i_clr_flg = clr & tgt;
  assign a_if.i_cpol = cpol;
  assign b_if.i_cpol = cpol;
  assign a_if.i_cpha = cpha;
  assign b_if.i_cpha = cpha;
  assign a_if.i_lsb_first = lsb;
  assign b_if.i_lsb_first = lsb;
  assign a_if.i_cs_sel = sel;
  assign b_if.i_cs_sel = sel;
  assign a_if.i_clk_div = div;
  assign b_if.i_clk_div = div;
  assign a_if.i_data_master = txw[7:0];
  assign b_if.i_data_master = txw;

  logic        cur_done, cur_busy, cur_sck, cur_mosi;
  logic [3:0]  cur_cs;
  logic [15:0] cur_rx;
  logic [4:0]  cur_bits;
  assign cur_done = tgt ? b_if.o_done_flg : a_if.o_done_flg;
  assign cur_busy = tgt ? b_if.o_busy : a_if.o_busy;
  assign cur_sck  = tgt ? b_if.o_SCK : a_if.o_SCK;
  assign cur_mosi = tgt ? b_if.o_MOSI : a_if.o_MOSI;
  assign cur_cs   = tgt ? {1'b1, b_if.o_CS} : a_if.o_CS;
  assign cur_rx   = tgt ? b_if.o_data_rx : {8'h00, a_if.o_data_rx};
  assign cur_bits = tgt ? b_if.o_bits : {1'b0, a_if.o_bits};

  typedef struct packed {
    logic        act, sck, miso;
    int          tx_n, nedge, last, cyc, hi, gap, min_per, max_per;
    logic [15:0] seq;
  } slv_t;

  slv_t sa = '0, sb = '0;

  function automatic logic tbit(input int k, input int w);
    logic [15:0] v;
    int          i;
    v = rxw;
    i = lsb ? k : (w - 1 - k);
    return v[i[3:0]];
  endfunction

  // Slave: shifts its word out and samples MOSI on the edges its mode dictates.
  function automatic slv_t slave_step(input slv_t s_in, input logic act, input logic sck,
                                      input logic mosi, input int w);
    slv_t s;
    logic lead;
    s = s_in;
    s.cyc++;
    if (act && !s.act) begin
      s.gap = s.hi;
      s.hi = 0;
      s.tx_n = 0;
      s.nedge = 0;
      s.seq = '0;
      s.min_per = 1000;
      s.max_per = 0;
      s.last = s.cyc;
      if (!cpha) begin
        s.miso = tbit(0, w);
        s.tx_n = 1;
      end
    end else if (act && sck !== s.sck) begin
      if (s.nedge > 0) begin
        if (s.cyc - s.last < s.min_per) s.min_per = s.cyc - s.last;
        if (s.cyc - s.last > s.max_per) s.max_per = s.cyc - s.last;
      end
      s.nedge++;
      s.last = s.cyc;
      lead = (sck != cpol);
      if (lead ^ cpha) s.seq = {s.seq[14:0], mosi};
      else if (s.tx_n < w) begin
        s.miso = tbit(s.tx_n, w);
        s.tx_n++;
      end
    end
    if (!act) s.hi++;
    s.act = act;
    s.sck = sck;
    return s;
  endfunction

  always @(posedge clk) begin
    #1;
    sa = slave_step(sa, ~&a_if.o_CS, a_if.o_SCK, a_if.o_MOSI, 8);
    a_if.i_MISO = sa.miso;
    sb = slave_step(sb, ~&b_if.o_CS, b_if.o_SCK, b_if.o_MOSI, 16);
    b_if.i_MISO = sb.miso;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic start(input logic with_clr);
    @(negedge clk);
    en = 1'b1;
    clr = with_clr;
    @(negedge clk);
    en = 1'b0;
    clr = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int k;
    k = 0;
    while (cur_done !== 1'b1 && k < lat + 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_latency"}, 32'(k + 1), 32'(lat));
  endtask

  initial begin
    // Reset state of both instances
    repeat (3) @(negedge clk);
    tgt = 1'b0;
    chk("rst_a_cs", 32'(cur_cs), 32'hF);
    chk("rst_a_sck", 32'(cur_sck), 32'h0);
    chk("rst_a_mosi", 32'(cur_mosi), 32'h0);
    chk("rst_a_busy", 32'(cur_busy), 32'h0);
    chk("rst_a_done", 32'(cur_done), 32'h0);
    chk("rst_a_rx", 32'(cur_rx), 32'h0);
    chk("rst_a_bits", 32'(cur_bits), 32'h0);
    chk("rst_b_cs", 32'(b_if.o_CS), 32'h7);
    chk("rst_b_busy", 32'(b_if.o_busy), 32'h0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Mode 0, div 0, CS1, AB out / CD in
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sel = 2'd1; div = 8'd0;
    txw = 16'h00AB; rxw = 16'h00CD;
    start(1'b1);
    chk("t1_cs", 32'(cur_cs), 32'hD);
    chk("t1_busy", 32'(cur_busy), 32'h1);
    chk("t1_done0", 32'(cur_done), 32'h0);
    chk("t1_mosi_first", 32'(cur_mosi), 32'h1);
    wait_done(21, "t1");
    chk("t1_rx", 32'(cur_rx), 32'hCD);
    chk("t1_mosi_seq", 32'(sa.seq[7:0]), 32'hAB);
    chk("t1_bits", 32'(cur_bits), 32'd8);
    chk("t1_half_period", 32'(sa.max_per), 32'd1);
    chk("t1_busy_end", 32'(cur_busy), 32'h0);
    chk("t1_cs_end", 32'(cur_cs), 32'hF);

    // Mode 3, div 3, LSB first, 23 out / 45 in
    cpol = 1'b1; cpha = 1'b1; lsb = 1'b1; sel = 2'd0; div = 8'd3;
    txw = 16'h0023; rxw = 16'h0045;
    start(1'b1);
    chk("t2_cs", 32'(cur_cs), 32'hE);
    chk("t2_sck_setup", 32'(cur_sck), 32'h1);
    wait_done(69, "t2");
    chk("t2_rx", 32'(cur_rx), 32'h45);
    chk("t2_mosi_seq", 32'(sa.seq[7:0]), 32'hC4);
    chk("t2_min_phase", 32'(sa.min_per), 32'd4);
    chk("t2_max_phase", 32'(sa.max_per), 32'd4);
    chk("t2_sck_idle", 32'(cur_sck), 32'h1);

    // i_en while busy ignored; clear coincident with done loses to set
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sel = 2'd2; div = 8'd0;
    txw = 16'h005A; rxw = 16'h0096;
    start(1'b1);
    repeat (4) @(negedge clk);
    en = 1'b1; txw = 16'h00FF;
    @(negedge clk);
    en = 1'b0;
    chk("t3_busy_mid", 32'(cur_busy), 32'h1);
    chk("t3_cs_mid", 32'(cur_cs), 32'hB);
    repeat (14) @(negedge clk);
    chk("t3_done_before", 32'(cur_done), 32'h0);
    clr = 1'b1;
    @(negedge clk);
    chk("t3_set_wins", 32'(cur_done), 32'h1);
    @(negedge clk);
    chk("t3_clr_next", 32'(cur_done), 32'h0);
    clr = 1'b0;
    chk("t3_rx", 32'(cur_rx), 32'h96);
    chk("t3_mosi_seq", 32'(sa.seq[7:0]), 32'h5A);
    chk("t3_idle", 32'(cur_busy), 32'h0);

    // Reset after 3 sampled bits, then a Mode 1 transfer
    cpol = 1'b0; cpha = 1'b0; lsb = 1'b0; sel = 2'd1; div = 8'd0;
    txw = 16'h003C; rxw = 16'h0077;
    start(1'b1);
    repeat (7) @(negedge clk);
    chk("t4_bits3", 32'(cur_bits), 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t4_rst_cs", 32'(cur_cs), 32'hF);
    chk("t4_rst_sck", 32'(cur_sck), 32'h0);
    chk("t4_rst_busy", 32'(cur_busy), 32'h0);
    chk("t4_rst_bits", 32'(cur_bits), 32'h0);
    chk("t4_rst_rx", 32'(cur_rx), 32'h0);
    rst_n = 1'b1;
    cpol = 1'b0; cpha = 1'b1; sel = 2'd3; txw = 16'h00EF; rxw = 16'h00F1;
    start(1'b1);
    chk("t4_cs", 32'(cur_cs), 32'h7);
    wait_done(21, "t4");
    chk("t4_rx", 32'(cur_rx), 32'hF1);
    chk("t4_mosi_seq", 32'(sa.seq[7:0]), 32'hEF);

    // 16-bit instance, all four modes back to back
    tgt = 1'b1; sel = 2'd2; div = 8'd1; lsb = 1'b0;
    txw = 16'hFE11; rxw = 16'h11FE;
    for (int m = 0; m < 4; m++) begin
      cpol = m[1];
      cpha = m[0];
      start(1'b1);
      chk("t5_cs", 32'(cur_cs), 32'hB);
      wait_done(69, "t5");
      chk("t5_rx", 32'(cur_rx), 32'h11FE);
      chk("t5_mosi_seq", 32'(sb.seq), 32'hFE11);
      chk("t5_bits", 32'(cur_bits), 32'd16);
      chk("t5_gap", 32'(sb.gap >= 1), 32'h1);
    end

    // Out-of-range chip select on the 3-CS instance
    sel = 2'd3; txw = 16'h1234;
    start(1'b0);
    chk("t6_busy", 32'(cur_busy), 32'h0);
    chk("t6_cs", 32'(cur_cs), 32'hF);
    chk("t6_done", 32'(cur_done), 32'h1);
    repeat (3) @(negedge clk);
    chk("t6_busy_late", 32'(cur_busy), 32'h0);
    chk("t6_cs_late", 32'(cur_cs), 32'hF);
    chk("t6_rx_hold", 32'(cur_rx), 32'h11FE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
